// File: rtl/prog_mem_loader.sv
// Serial program loader: takes a framed byte stream (count, word pairs, checksum)
// and writes it into CPU program memory while holding the CPU halted.
module prog_mem_loader #(
  parameter int ADDR_W  = 6,
  parameter int INS_W   = 13,
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              pm_we,
  output logic [ADDR_W-1:0] pm_waddr,
  output logic [INS_W-1:0]  pm_wdata,
  output logic              cpu_halt,
  output logic              cpu_pc_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word counter must hold DEPTH itself after the final increment.
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, COUNT, LO, HI, WRITE, CSUM, DONE, ERR} state_t;

  state_t            state, nxt;
  logic [7:0]        n_words;
  logic [7:0]        lo_byte;
  logic [7:0]        xsum;
  logic [CNT_W-1:0]  wcnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept, rx_state, timed_out, count_bad, hi_bad, last_word;

  assign accept    = rx_valid && rx_ready;
  assign rx_state  = state inside {COUNT, LO, HI, CSUM};
  assign timed_out = rx_state && !accept && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign count_bad = (rx_data == 8'd0) || (int'(rx_data) > DEPTH);
  assign hi_bad    = (rx_data >> (INS_W - 8)) != 8'd0;
  assign last_word = (int'(wcnt) + 1) == int'(n_words);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (load_start) nxt = COUNT;
      COUNT: if (accept) nxt = count_bad ? ERR : LO;
             else if (timed_out) nxt = ERR;
      LO:    if (accept) nxt = HI;
             else if (timed_out) nxt = ERR;
      HI:    if (accept) nxt = hi_bad ? ERR : WRITE;
             else if (timed_out) nxt = ERR;
      WRITE: nxt = last_word ? CSUM : LO;
      CSUM:  if (accept) nxt = (rx_data == xsum) ? DONE : ERR;
             else if (timed_out) nxt = ERR;
      DONE:  nxt = IDLE;
      ERR:   if (load_start) nxt = COUNT;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      pm_we      <= 1'b0;
      pm_waddr   <= '0;
      pm_wdata   <= '0;
      cpu_halt   <= 1'b0;
      cpu_pc_rst <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      n_words    <= '0;
      lo_byte    <= '0;
      xsum       <= '0;
      wcnt       <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= nxt;
      rx_ready   <= nxt inside {COUNT, LO, HI, CSUM};
      pm_we      <= (nxt == WRITE);
      cpu_halt   <= (nxt != IDLE);
      busy       <= (nxt != IDLE) && (nxt != ERR);
      done       <= (nxt == DONE);
      cpu_pc_rst <= (nxt == DONE);
      err        <= (nxt == ERR);
      idle_cnt   <= (accept || !rx_state || nxt != state) ? '0 : idle_cnt + 1'b1;

      if (nxt == COUNT && state != COUNT) begin
        xsum <= '0;
        wcnt <= '0;
      end
      if (accept && state != CSUM)
        xsum <= xsum ^ rx_data;

      if (accept && state == COUNT) begin
        n_words <= rx_data;
        wcnt    <= '0;
      end
      if (accept && state == LO)
        lo_byte <= rx_data;
      if (accept && state == HI && !hi_bad) begin
        pm_waddr <= wcnt[ADDR_W-1:0];
        pm_wdata <= {rx_data[INS_W-9:0], lo_byte};
      end
      if (state == WRITE)
        wcnt <= wcnt + 1'b1;
    end
  end

endmodule
